// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states, divider helper and parity selectors for the UART transmitter
package uart_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_state_t;

    localparam int PAR_EVEN = 0;
    localparam int PAR_ODD  = 1;

    function automatic int calc_div(input int clk_freq, input int baud_rate);
        return clk_freq / baud_rate;
    endfunction

endpackage

// File: rtl/baud_tick_gen.sv
// baud_tick_gen: free-running bit-period divider, cleared at frame start and parked at 0 when disabled
module baud_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_cnt;

    assign tick = enable && (r_cnt == LAST);

    // count 0..DIV-1 while enabled, wrapping on the tick
    always_ff @(posedge clk) begin
        if (reset || clear || !enable || tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/uart_tx_sequencer.sv
// uart_tx_sequencer: valid/ready byte sink that serialises one word per frame onto a UART line
module uart_tx_sequencer
    import uart_pkg::*;
#(
    parameter int CLK_FREQ   = 25000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DIV        = calc_div(CLK_FREQ, BAUD_RATE),
    parameter int DATA_BITS  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 baud_tick
);

    localparam int IW = $clog2(DATA_BITS + 1);
    localparam logic [IW-1:0] LAST_BIT = IW'(DATA_BITS - 1);
    localparam logic LAST_STOP = 1'(STOP_BITS - 1);

    uart_state_t          r_state, w_state_n;
    logic [DATA_BITS-1:0] r_shift, w_shift_n;
    logic [IW-1:0]        r_idx, w_idx_n;
    logic                 r_stop, w_stop_n;
    logic                 r_par, w_par_n;
    logic                 r_tx, r_busy, r_ready, r_done;
    logic                 w_tick, w_clear, w_done_n, w_tx_n;

    baud_tick_gen #(.DIV(DIV)) u_baud (
        .clk    (clk),
        .reset  (reset),
        .clear  (w_clear),
        .enable (r_state != IDLE),
        .tick   (w_tick)
    );

    // next-state, datapath updates and the line level for the coming cycle
    always_comb begin
        w_state_n = r_state;
        w_shift_n = r_shift;
        w_idx_n   = r_idx;
        w_stop_n  = r_stop;
        w_par_n   = r_par;
        w_done_n  = 1'b0;
        w_clear   = 1'b0;
        unique case (r_state)
            IDLE: if (tx_valid) begin
                w_state_n = START;
                w_shift_n = tx_data;
                w_idx_n   = '0;
                w_stop_n  = 1'b0;
                w_par_n   = (^tx_data) ^ (PARITY_ODD == PAR_ODD);
                w_clear   = 1'b1;
            end
            START: if (w_tick) w_state_n = DATA;
            DATA: if (w_tick) begin
                w_shift_n = r_shift >> 1;
                w_idx_n   = r_idx + 1'b1;
                if (r_idx == LAST_BIT) w_state_n = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: if (w_tick) w_state_n = STOP;
            STOP: if (w_tick) begin
                w_stop_n = 1'b1;
                if (r_stop == LAST_STOP) begin
                    w_state_n = IDLE;
                    w_done_n  = 1'b1;
                end
            end
            default: w_state_n = IDLE;
        endcase
        w_tx_n = (w_state_n == START)  ? 1'b0 :
                 (w_state_n == DATA)   ? w_shift_n[0] :
                 (w_state_n == PARITY) ? w_par_n : 1'b1;
    end

    // state and registered outputs; reset wins over a simultaneous handshake
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_shift <= '0;
            r_idx   <= '0;
            r_stop  <= 1'b0;
            r_par   <= 1'b0;
            r_tx    <= 1'b1;
            r_busy  <= 1'b0;
            r_ready <= 1'b1;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_shift <= w_shift_n;
            r_idx   <= w_idx_n;
            r_stop  <= w_stop_n;
            r_par   <= w_par_n;
            r_tx    <= w_tx_n;
            r_busy  <= w_state_n != IDLE;
            r_ready <= w_state_n == IDLE;
            r_done  <= w_done_n;
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign tx_ready   = r_ready;
    assign frame_done = r_done;
    assign baud_tick  = w_tick;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb_uart_tx_sequencer: directed checks of 8N1, 8E1, 8O1 and 8N2 instances at DIV = 10
module tb_uart_tx_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] vv = '0;
    logic [7:0] dd [4];
    wire  [3:0] rdy, txv, bsy, dn, tk;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    uart_tx_sequencer #(.CLK_FREQ(1000), .BAUD_RATE(100)) u_8n1 (
        .clk(clk), .reset(reset), .tx_data(dd[0]), .tx_valid(vv[0]), .tx_ready(rdy[0]),
        .tx(txv[0]), .busy(bsy[0]), .frame_done(dn[0]), .baud_tick(tk[0]));
    uart_tx_sequencer #(.CLK_FREQ(1000), .BAUD_RATE(100), .PARITY_EN(1), .PARITY_ODD(0)) u_8e1 (
        .clk(clk), .reset(reset), .tx_data(dd[1]), .tx_valid(vv[1]), .tx_ready(rdy[1]),
        .tx(txv[1]), .busy(bsy[1]), .frame_done(dn[1]), .baud_tick(tk[1]));
    uart_tx_sequencer #(.CLK_FREQ(1000), .BAUD_RATE(100), .PARITY_EN(1), .PARITY_ODD(1)) u_8o1 (
        .clk(clk), .reset(reset), .tx_data(dd[2]), .tx_valid(vv[2]), .tx_ready(rdy[2]),
        .tx(txv[2]), .busy(bsy[2]), .frame_done(dn[2]), .baud_tick(tk[2]));
    uart_tx_sequencer #(.CLK_FREQ(1000), .BAUD_RATE(100), .STOP_BITS(2)) u_8n2 (
        .clk(clk), .reset(reset), .tx_data(dd[3]), .tx_valid(vv[3]), .tx_ready(rdy[3]),
        .tx(txv[3]), .busy(bsy[3]), .frame_done(dn[3]), .baud_tick(tk[3]));

    task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
        checks++;
        assert (o === e) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // par < 0 means no parity bit; hold keeps tx_valid high; jam scribbles inputs while busy
    task automatic frame(input int u, input logic [7:0] w, input int par, input int nstop,
                         input bit hold, input bit jam);
        int  n;
        logic e;
        n = 9 + ((par >= 0) ? 1 : 0) + nstop;
        dd[u] = w;
        vv[u] = 1'b1;
        @(negedge clk);
        if (!hold) vv[u] = 1'b0;
        for (int k = 0; k < n; k++) begin
            e = (k == 0) ? 1'b0 : (k <= 8) ? w[k-1] : (par >= 0 && k == 9) ? par[0] : 1'b1;
            for (int c = 0; c < 10; c++) begin
                chk($sformatf("tx u%0d bit%0d cyc%0d", u, k, c), {31'b0, txv[u]}, {31'b0, e});
                chk($sformatf("busy u%0d bit%0d cyc%0d", u, k, c), {31'b0, bsy[u]}, 1);
                chk($sformatf("ready u%0d bit%0d cyc%0d", u, k, c), {31'b0, rdy[u]}, 0);
                chk($sformatf("done u%0d bit%0d cyc%0d", u, k, c), {31'b0, dn[u]}, 0);
                chk($sformatf("tick u%0d bit%0d cyc%0d", u, k, c), {31'b0, tk[u]}, (c == 9) ? 1 : 0);
                if (jam) begin
                    dd[u] = 8'($urandom);
                    vv[u] = (k == n - 1 && c == 9) ? 1'b0 : 1'($urandom);
                end
                @(negedge clk);
            end
        end
        chk($sformatf("end done u%0d", u), {31'b0, dn[u]}, 1);
        chk($sformatf("end ready u%0d", u), {31'b0, rdy[u]}, 1);
        chk($sformatf("end busy u%0d", u), {31'b0, bsy[u]}, 0);
        chk($sformatf("end tx u%0d", u), {31'b0, txv[u]}, 1);
    endtask

    initial begin
        for (int i = 0; i < 4; i++) dd[i] = 8'h00;
        repeat (3) @(negedge clk);
        chk("rst tx", {28'b0, txv}, 32'hF);
        chk("rst ready", {28'b0, rdy}, 32'hF);
        chk("rst busy", {28'b0, bsy}, 0);
        chk("rst done", {28'b0, dn}, 0);
        chk("rst tick", {28'b0, tk}, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        chk("idle tick", {28'b0, tk}, 0);

        frame(0, 8'h55, -1, 1, 1'b0, 1'b0);
        frame(1, 8'h07, 1, 1, 1'b0, 1'b0);
        frame(2, 8'h07, 0, 1, 1'b0, 1'b0);
        frame(3, 8'hFF, -1, 2, 1'b0, 1'b0);
        frame(0, 8'hA5, -1, 1, 1'b1, 1'b0);
        frame(0, 8'h3C, -1, 1, 1'b0, 1'b0);
        @(negedge clk);
        chk("post b2b done", {31'b0, dn[0]}, 0);
        chk("post b2b busy", {31'b0, bsy[0]}, 0);

        dd[0] = 8'h00;
        vv[0] = 1'b1;
        @(negedge clk);
        vv[0] = 1'b0;
        repeat (40) @(negedge clk);
        chk("mid data bit3 tx", {31'b0, txv[0]}, 0);
        chk("mid data bit3 busy", {31'b0, bsy[0]}, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort tx", {31'b0, txv[0]}, 1);
        chk("abort busy", {31'b0, bsy[0]}, 0);
        chk("abort ready", {31'b0, rdy[0]}, 1);
        chk("abort done", {31'b0, dn[0]}, 0);
        for (int c = 0; c < 120; c++) begin
            chk($sformatf("abort quiet done cyc%0d", c), {31'b0, dn[0]}, 0);
            chk($sformatf("abort quiet tx cyc%0d", c), {31'b0, txv[0]}, 1);
            @(negedge clk);
        end
        frame(0, 8'h96, -1, 1, 1'b0, 1'b0);

        reset = 1'b1;
        vv[1] = 1'b1;
        dd[1] = 8'h01;
        @(negedge clk);
        vv[1] = 1'b0;
        reset = 1'b0;
        chk("rst vs handshake busy", {31'b0, bsy[1]}, 0);
        chk("rst vs handshake tx", {31'b0, txv[1]}, 1);
        @(negedge clk);
        chk("rst vs handshake stays idle", {31'b0, bsy[1]}, 0);

        frame(3, 8'hC3, -1, 2, 1'b0, 1'b1);
        frame(1, 8'h5B, 1, 1, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
